instr_stream_driver: RTL and testbench

- Parametrised instruction-memory model and program sequencer for the 16-bit pipelined CPU; it replaces hand-timed instruction stimulus.
- A program is loaded through a valid/ready port into an internal buffer.
- On start, the block serves CPU fetches (i_readM/i_address) with configurable, pipelined read latency and drives the tri-state instruction bus enable.
- It watches is_halted and a cycle-timeout counter to end the run and report fetch and cycle counts.

---
 rtl/instr_stream_driver.sv | 169 ++++++++++++++++
 tb/tb_instr_stream_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_driver.sv
// Instruction-memory model and program sequencer for the 16-bit pipelined CPU.
// A program is loaded over a valid/ready port. A run then serves CPU fetches
// through a fixed-latency read pipeline until the CPU halts or the cycle
// budget runs out.
module instr_stream_driver #(
  parameter int unsigned            WORD_SIZE = 16,
  parameter int unsigned            DEPTH     = 32,
  parameter int unsigned            ADDR_W    = 5,
  parameter int unsigned            LATENCY   = 1,
  parameter logic [WORD_SIZE-1:0]   FILL_WORD = 16'hF01D,
  parameter int unsigned            TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic                 start,
  input  logic                 i_readM,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic [WORD_SIZE-1:0] i_data_out,
  output logic                 i_data_en,
  input  logic                 is_halted,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic [ADDR_W:0]      prog_len,
  output logic [WORD_SIZE-1:0] fetch_count,
  output logic [WORD_SIZE-1:0] cycle_count
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;

  // Program storage and its length; both survive reset so a program can be rerun.
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [LEN_W-1:0]     len_q;

  // Read pipeline: stage 0 holds the word captured on the request edge.
  logic [LATENCY-1:0]   vld_q;
  logic [WORD_SIZE-1:0] word_q [LATENCY];

  logic                 run_start_c;
  logic                 load_acc_c;
  logic                 req_c;
  logic                 flush_c;
  logic                 timeout_c;
  logic                 last_in_c;
  logic [ADDR_W-1:0]    wr_addr_c;
  logic [WORD_SIZE-1:0] rd_word_c;
  logic [WORD_SIZE-1:0] cyc_inc_c;
  logic [LEN_W-1:0]     len_inc_c;

  // Datapath decode shared by the FSM and the registered outputs.
  assign run_start_c = start && (state_q != ST_RUN);
  assign load_acc_c  = ld_valid && ld_ready;
  assign req_c       = (state_q == ST_RUN) && i_readM;
  assign flush_c     = (state_q == ST_RUN) && (state_d != ST_RUN);
  assign cyc_inc_c   = (cycle_count == {WORD_SIZE{1'b1}}) ? cycle_count
                                                           : cycle_count + WORD_SIZE'(1);
  assign timeout_c   = (state_q == ST_RUN) && !is_halted &&
                       (cyc_inc_c >= WORD_SIZE'(TIMEOUT));
  assign len_inc_c   = (state_q == ST_LOAD) ? len_q + LEN_W'(1) : LEN_W'(1);
  assign wr_addr_c   = (state_q == ST_LOAD) ? len_q[ADDR_W-1:0] : '0;
  assign rd_word_c   = (i_address < WORD_SIZE'(len_q)) ? mem[i_address[ADDR_W-1:0]]
                                                       : FILL_WORD;

  // Valid bit about to land in the last pipeline stage (counts a served fetch).
  if (LATENCY == 1) begin : g_lat1
    assign last_in_c = req_c;
  end else begin : g_latn
    assign last_in_c = vld_q[LATENCY-2];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and load handshake; start beats a same-cycle load word.
  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        ld_ready = !start;
        if (start)         state_d = ST_RUN;
        else if (ld_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ld_ready = !start && (len_q < LEN_W'(DEPTH));
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (is_halted || timeout_c) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Program buffer write and length tracking (not cleared by reset).
  always_ff @(posedge clk) begin
    if (!reset && load_acc_c) begin
      mem[wr_addr_c] <= ld_data;
      len_q          <= len_inc_c;
    end
  end

  // Fetch pipeline; a halt, timeout or reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset || flush_c) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        word_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= req_c;
      word_q[0] <= req_c ? rd_word_c : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        word_q[i] <= word_q[i-1];
      end
    end
  end

  assign i_data_en  = vld_q[LATENCY-1];
  assign i_data_out = word_q[LATENCY-1];

  // Status flags and run counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      prog_len    <= '0;
      fetch_count <= '0;
      cycle_count <= '0;
    end else begin
      busy <= (state_d == ST_LOAD) || (state_d == ST_RUN);
      if (load_acc_c)       prog_len <= len_inc_c;
      else if (run_start_c) prog_len <= len_q;
      if (run_start_c) begin
        done        <= 1'b0;
        timed_out   <= 1'b0;
        fetch_count <= '0;
        cycle_count <= '0;
      end else if (state_q == ST_RUN) begin
        cycle_count <= cyc_inc_c;
        if (flush_c) begin
          done      <= 1'b1;
          timed_out <= timeout_c;
        end else if (last_in_c) begin
          fetch_count <= fetch_count + WORD_SIZE'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_stream_driver.sv
// Bench for instr_stream_driver: two instances (latency 1 and 3) share one
// randomized stimulus stream and are compared every cycle against a
// transaction-level model of the program buffer, run control and fetch timing.
module tb_instr_stream_driver;

  localparam int unsigned WS      = 16;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned TIMEOUT = 1024;
  localparam int          HMASK   = 16383;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, ld_valid, start, i_readM, is_halted;
  logic [WS-1:0] ld_data, i_address;

  logic          d1_ld_ready, d1_en, d1_busy, d1_done, d1_to;
  logic [WS-1:0] d1_dout, d1_fc, d1_cc;
  logic [5:0]    d1_plen;
  logic          d3_ld_ready, d3_en, d3_busy, d3_done, d3_to;
  logic [WS-1:0] d3_dout, d3_fc, d3_cc;
  logic [5:0]    d3_plen;

  instr_stream_driver #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(d1_ld_ready),
    .ld_data(ld_data), .start(start), .i_readM(i_readM), .i_address(i_address),
    .i_data_out(d1_dout), .i_data_en(d1_en), .is_halted(is_halted),
    .busy(d1_busy), .done(d1_done), .timed_out(d1_to), .prog_len(d1_plen),
    .fetch_count(d1_fc), .cycle_count(d1_cc));

  instr_stream_driver #(.LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(d3_ld_ready),
    .ld_data(ld_data), .start(start), .i_readM(i_readM), .i_address(i_address),
    .i_data_out(d3_dout), .i_data_en(d3_en), .is_halted(is_halted),
    .busy(d3_busy), .done(d3_done), .timed_out(d3_to), .prog_len(d3_plen),
    .fetch_count(d3_fc), .cycle_count(d3_cc));

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=load 2=run 3=done.
  int            mode = 0;
  logic [WS-1:0] mem_m [DEPTH];
  int            len = 0;
  int            plen_o = 0;
  int            cc = 0;
  int            fc [2];
  bit            done_o = 0, to_o = 0, busy_o = 0;
  bit            en_o [2];
  logic [WS-1:0] dout_o [2];
  int            e = 0;
  int            last_flush = 0;
  bit            req_hist [HMASK+1];
  logic [WS-1:0] word_hist [HMASK+1];

  function automatic bit exp_ready();
    return (mode != 2) && !start && ((mode != 1) || (len < int'(DEPTH)));
  endfunction

  task automatic enter_run();
    mode = 2; cc = 0; fc[0] = 0; fc[1] = 0; done_o = 0; to_o = 0; plen_o = len;
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit            flushed;
    logic [WS-1:0] a;
    int            r, lat;
    e++;
    flushed = 0;
    req_hist[e & HMASK] = 0;
    if (reset) begin
      mode = 0; cc = 0; fc[0] = 0; fc[1] = 0; done_o = 0; to_o = 0; plen_o = 0;
      flushed = 1;
    end else begin
      case (mode)
        0, 3: begin
          if (start) enter_run();
          else if (ld_valid) begin
            mem_m[0] = ld_data; len = 1; plen_o = 1; mode = 1;
          end
        end
        1: begin
          if (start) enter_run();
          else if (ld_valid && len < int'(DEPTH)) begin
            mem_m[len] = ld_data; len++; plen_o = len;
          end
        end
        default: begin
          if (i_readM) begin
            a = i_address;
            req_hist[e & HMASK]  = 1;
            word_hist[e & HMASK] = (32'(a) < len) ? mem_m[a[4:0]] : 16'hF01D;
          end
          if (cc < 65535) cc++;
          if (is_halted) begin
            mode = 3; done_o = 1; flushed = 1;
          end else if (cc >= int'(TIMEOUT)) begin
            mode = 3; done_o = 1; to_o = 1; flushed = 1;
          end
        end
      endcase
    end
    busy_o = (mode == 1) || (mode == 2);
    if (flushed) last_flush = e;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 1 : 3;
      r = e - lat + 1;
      en_o[k] = 0;
      dout_o[k] = '0;
      if (r > last_flush && req_hist[r & HMASK]) begin
        en_o[k] = 1;
        dout_o[k] = word_hist[r & HMASK];
        fc[k]++;
      end
    end
  endtask

  task automatic check_outputs();
    check("d1_en",    32'(d1_en),   32'(en_o[0]));
    check("d1_data",  32'(d1_dout), 32'(dout_o[0]));
    check("d1_fetch", 32'(d1_fc),   32'(fc[0]));
    check("d3_en",    32'(d3_en),   32'(en_o[1]));
    check("d3_data",  32'(d3_dout), 32'(dout_o[1]));
    check("d3_fetch", 32'(d3_fc),   32'(fc[1]));
    check("cycles",   32'(d1_cc),   32'(cc));
    check("cycles3",  32'(d3_cc),   32'(cc));
    check("busy",     32'(d1_busy), 32'(busy_o));
    check("done",     32'(d1_done), 32'(done_o));
    check("timed_out",32'(d1_to),   32'(to_o));
    check("prog_len", 32'(d1_plen), 32'(plen_o));
    check("busy3",    32'({d3_busy, d3_done, d3_to}), 32'({busy_o, done_o, to_o}));
    check("prog_len3",32'(d3_plen), 32'(plen_o));
  endtask

  // One clock: check the handshake, step the model, then check registered outputs.
  task automatic step();
    #1;
    if (!reset) begin
      check("ld_ready",  32'(d1_ld_ready), 32'(exp_ready()));
      check("ld_ready3", 32'(d3_ld_ready), 32'(exp_ready()));
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_inputs();
    reset = 0; ld_valid = 0; start = 0; i_readM = 0; is_halted = 0;
    ld_data = WS'($urandom); i_address = '0;
  endtask

  task automatic rand_fetch(input int pct);
    clear_inputs();
    i_readM = ($urandom_range(99) < pct);
    i_address = ($urandom_range(9) == 0) ? WS'($urandom) : WS'($urandom_range(39));
  endtask

  logic [WS-1:0] prog5 [5];
  logic [WS-1:0] first_word;
  int            guard;

  initial begin
    prog5[0] = 16'hD600; prog5[1] = 16'h7000; prog5[2] = 16'hF9C0;
    prog5[3] = 16'h8F02; prog5[4] = 16'hDE00;
    clear_inputs();
    @(negedge clk);
    reset = 1; step(); step();
    clear_inputs(); step();

    // Load the five-word program, run it, fetch 0..4 back to back, then halt.
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); ld_valid = 1; ld_data = prog5[i]; step();
    end
    check("plen5", 32'(d1_plen), 32'd5);
    clear_inputs(); start = 1; step();
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); i_readM = 1; i_address = WS'(i); step();
      check("word_l1", 32'(d1_dout), 32'(prog5[i]));
      if (i == 2) check("word_l3", 32'(d3_dout), 32'(prog5[0]));
    end
    clear_inputs(); step(); step();
    check("fetch5", 32'(d1_fc), 32'd5);
    check("fetch5_l3", 32'(d3_fc), 32'd5);
    clear_inputs(); is_halted = 1; step();

    // Rerun from DONE: out-of-range addresses return the fill word.
    clear_inputs(); start = 1; step();
    clear_inputs(); i_readM = 1; i_address = 16'h0007; step();
    check("fill7", 32'(d1_dout), 32'h0000F01D);
    clear_inputs(); i_readM = 1; i_address = 16'h0020; step();
    check("fill20", 32'(d1_dout), 32'h0000F01D);
    for (int i = 0; i < 40; i++) begin rand_fetch(70); step(); end
    clear_inputs(); is_halted = 1; step();

    // Overfill: DEPTH+3 words, no wrap, entry 0 intact.
    for (int i = 0; i < int'(DEPTH) + 3; i++) begin
      clear_inputs(); ld_valid = 1; step();
      if (i == 0) first_word = mem_m[0];
    end
    check("plen_full", 32'(d1_plen), 32'd32);
    check("rdy_full", 32'(d1_ld_ready), 32'd0);
    clear_inputs(); start = 1; step();
    clear_inputs(); i_readM = 1; i_address = '0; step();
    check("nowrap", 32'(d1_dout), 32'(first_word));
    for (int i = 0; i < 30; i++) begin rand_fetch(80); step(); end
    clear_inputs(); is_halted = 1; step();

    // Timeout run with no halt.
    clear_inputs(); start = 1; step();
    guard = 0;
    while (!d1_done && guard < int'(TIMEOUT) + 20) begin
      rand_fetch(50); step(); guard++;
    end
    check("to_done", 32'(d1_done), 32'd1);
    check("to_flag", 32'(d1_to), 32'd1);
    check("to_cycles", 32'(d1_cc), 32'(TIMEOUT));

    // Halt coincides with the timeout edge: halt wins.
    clear_inputs(); start = 1; step();
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin rand_fetch(30); step(); end
    clear_inputs(); is_halted = 1; step();
    check("tie_done", 32'(d1_done), 32'd1);
    check("tie_to", 32'(d1_to), 32'd0);
    check("tie_cycles", 32'(d1_cc), 32'(TIMEOUT));

    // Reset mid-run with fetches in flight, then rerun the retained program.
    for (int i = 0; i < 6; i++) begin clear_inputs(); ld_valid = 1; step(); end
    clear_inputs(); start = 1; step();
    for (int i = 0; i < 3; i++) begin
      clear_inputs(); i_readM = 1; i_address = WS'(i); step();
    end
    clear_inputs(); reset = 1; step();
    check("rst_en3", 32'(d3_en), 32'd0);
    check("rst_cnt", 32'({d1_cc, d1_fc}), 32'd0);
    clear_inputs(); start = 1; ld_valid = 1; step();
    for (int i = 0; i < 8; i++) begin
      clear_inputs(); i_readM = 1; i_address = WS'(i); step();
    end
    clear_inputs(); is_halted = 1; step();

    // Random soak across all modes.
    for (int i = 0; i < 2000; i++) begin
      rand_fetch(60);
      reset     = ($urandom_range(199) == 0);
      start     = ($urandom_range(29) == 0);
      ld_valid  = ($urandom_range(3) == 0);
      is_halted = ($urandom_range(49) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
